// File: rtl/mem_arbiter_pkg.sv
// Types and constants shared by the two-port memory arbiter and its users.
package mem_arbiter_pkg;
`include "constants.svh"

  localparam int ADDR_W          = `PADDR_W;
  localparam int WORD_W          = `WORD_W;
  localparam int WD_W            = 5;
  localparam int TIMEOUT_DEFAULT = `MEM_TIMEOUT_DEFAULT;

  typedef enum logic [1:0] {
    ST_IDLE  = `MEM_ARB_IDLE,
    ST_ISSUE = `MEM_ARB_ISSUE,
    ST_RESP  = `MEM_ARB_RESP
  } arb_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_t;

endpackage

// File: rtl/constants.svh
// Shared width and encoding constants for the memory subsystem.
`ifndef CONSTANTS_SVH
`define CONSTANTS_SVH

`define PADDR_W 18
`define WORD_W 36
`define PADDR [`PADDR_W-1:0]
`define WORD [`WORD_W-1:0]

`define MEM_ARB_IDLE 2'd0
`define MEM_ARB_ISSUE 2'd1
`define MEM_ARB_RESP 2'd2

`define MEM_TIMEOUT_DEFAULT 16

`endif

// File: rtl/mem_arbiter.sv
// Shares one memory port between requester 0 (CPU) and requester 1 (I/O),
// with a per-access watchdog that reports non-existent memory.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT   = TIMEOUT_DEFAULT,
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [WORD_W-1:0] r0_wdata,
  input  logic              r0_read,
  input  logic              r0_write,
  output logic              r0_ack,
  output logic              r0_nxm,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [WORD_W-1:0] r1_wdata,
  input  logic              r1_read,
  input  logic              r1_write,
  output logic              r1_ack,
  output logic              r1_nxm,
  output logic [WORD_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [WORD_W-1:0] mem_read_data,
  input  logic              read_ack,
  input  logic              write_ack
);

  arb_state_t        state_reg, state_next;
  arb_op_t           op_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [WORD_W-1:0] wdata_reg;
  logic              grant_reg;
  logic              prio_reg;
  logic              nxm_reg;
  logic [WD_W-1:0]   wd_cnt_reg;

  logic req0, req1;
  logic load, load_idx;
  logic mem_ack, timeout_hit;
  logic in_issue, in_resp;

  // Returns the winning requester index; prio names the tie winner.
  function automatic logic pick(input logic r0, input logic r1,
                                input logic prio, input logic fixed_pri);
    if (r0 && r1) return fixed_pri ? 1'b0 : prio;
    return r1;
  endfunction

  assign req0        = r0_read | r0_write;
  assign req1        = r1_read | r1_write;
  assign mem_ack     = (op_reg == OP_READ) ? read_ack : write_ack;
  assign timeout_hit = (TIMEOUT != 0) && (int'(wd_cnt_reg) >= TIMEOUT - 1);
  assign in_issue    = (state_reg == ST_ISSUE);
  assign in_resp     = (state_reg == ST_RESP);

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    load_idx   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req0 || req1) begin
          load       = 1'b1;
          load_idx   = pick(req0, req1, prio_reg, FIXED_PRI);
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem_ack || timeout_hit) state_next = ST_RESP;
      end
      ST_RESP: begin
        // The just-served requester is still dropping its request; only the other one counts.
        if (grant_reg ? req0 : req1) begin
          load       = 1'b1;
          load_idx   = ~grant_reg;
          state_next = ST_ISSUE;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      op_reg     <= OP_READ;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      grant_reg  <= 1'b0;
      prio_reg   <= 1'b0;
      nxm_reg    <= 1'b0;
      wd_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        grant_reg  <= load_idx;
        addr_reg   <= load_idx ? r1_addr : r0_addr;
        wdata_reg  <= load_idx ? r1_wdata : r0_wdata;
        op_reg     <= (load_idx ? r1_read : r0_read) ? OP_READ : OP_WRITE;
        nxm_reg    <= 1'b0;
        wd_cnt_reg <= '0;
      end else if (in_issue) begin
        if (!mem_ack && timeout_hit) nxm_reg <= 1'b1;
        if (wd_cnt_reg != {WD_W{1'b1}}) wd_cnt_reg <= wd_cnt_reg + 1'b1;
      end
      if (in_resp) prio_reg <= ~grant_reg;
    end
  end

  // The memory port only ever reflects latched state, never live requester inputs.
  assign mem_addr       = in_issue ? addr_reg : '0;
  assign mem_write_data = in_issue ? wdata_reg : '0;
  assign mem_read       = in_issue && (op_reg == OP_READ);
  assign mem_write      = in_issue && (op_reg == OP_WRITE);

  assign r0_ack = in_resp && !grant_reg;
  assign r1_ack = in_resp && grant_reg;
  assign r0_nxm = r0_ack && nxm_reg;
  assign r1_nxm = r1_ack && nxm_reg;
  assign rdata  = (in_resp && (op_reg == OP_READ) && !nxm_reg) ? mem_read_data : '0;

endmodule
